// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
//   Shared definitions for the key event decoder:
//     - state_t  : FSM state encoding (IDLE, PRESS, HOLD, WAIT2, PRESS2)
//     - DEF_*    : default cycle counts for a 50 MHz system clock
//     - sat_inc  : 32-bit increment that sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
package key_event_pkg;

    localparam int CNT_W = 32;

    localparam int unsigned DEF_LONG_CNT   = 50_000_000; // 1 s
    localparam int unsigned DEF_REPEAT_CNT = 10_000_000; // 200 ms
    localparam int unsigned DEF_DCLICK_CNT = 15_000_000; // 300 ms

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
//   Two-flop register on the debounced key level plus press/release edge
//   detection. Both flops reset to the released level, so a key held through
//   reset is seen as a fresh press once reset drops.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous reset, active-high
//   key_i  in   debounced key level
//   act_o  out  key currently pressed (from key_q)
//   pe_o   out  press edge, one cycle
//   re_o   out  release edge, one cycle
// -----------------------------------------------------------------------------
module key_edge #(
    parameter logic KEY_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic act_o,
    output logic pe_o,
    output logic re_o
);

    // key_q is the sampled level, key_d the same level one cycle older.
    logic key_q;
    logic key_d;
    logic prev_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= ~KEY_ACTIVE;
            key_d <= ~KEY_ACTIVE;
        end else begin
            key_q <= key_i;
            key_d <= key_q;
        end
    end

    assign act_o    = (key_q == KEY_ACTIVE);
    assign prev_act = (key_d == KEY_ACTIVE);
    assign pe_o     = act_o & ~prev_act;
    assign re_o     = ~act_o & prev_act;

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//   Turns the debounced key level into one-cycle event pulses: press, release,
//   short-press, long-press, auto-repeat and (optionally) double-click.
//   Optional feature macro: KEY_DCLICK_EN
//     defined   : WAIT2/PRESS2 states exist, short_o is deferred by DCLICK_CNT
//                 after release and replaced by dclick_o on a second press
//     undefined : short_o fires together with release_o, dclick_o is 0
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   key_i      in   debounced key level
//   press_o    out  pulse on each press edge
//   release_o  out  pulse on each release edge
//   short_o    out  pulse for a press released before LONG_CNT
//   long_o     out  pulse after LONG_CNT held cycles
//   repeat_o   out  pulse every REPEAT_CNT cycles while held after long_o
//   dclick_o   out  pulse on a second press inside the double-click window
//   pressed_o  out  registered pressed level
// -----------------------------------------------------------------------------
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter logic        KEY_ACTIVE = 1'b0,
    parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
    parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT,
    parameter int unsigned DCLICK_CNT = DEF_DCLICK_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic dclick_o,
    output logic pressed_o
);

    localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT - 1;
    // Wraps to all-ones when REPEAT_CNT is 0; the compare is gated off then.
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - 1;

    logic act;
    logic pe;
    logic re;

    key_edge #(
        .KEY_ACTIVE (KEY_ACTIVE)
    ) u_edge (
        .clk   (clk),
        .rst   (rst),
        .key_i (key_i),
        .act_o (act),
        .pe_o  (pe),
        .re_o  (re)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             dclick_q, dclick_d;
    logic             pressed_q;

`ifdef KEY_DCLICK_EN
    localparam logic [CNT_W-1:0] DCLICK_LAST = DCLICK_CNT - 1;
`else
    logic unused_dclick_cnt;
    assign unused_dclick_cnt = ^DCLICK_CNT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            dclick_q  <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
            dclick_q  <= dclick_d;
            pressed_q <= act;
        end
    end

    // Edge checks come before threshold checks in every branch, so a release
    // beats a same-cycle long/repeat and a press beats a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = sat_inc(cnt_q);
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;
        dclick_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pe) begin
                    press_d = 1'b1;
                    state_d = ST_PRESS;
                end
            end

            ST_PRESS: begin
                if (re) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
`ifdef KEY_DCLICK_EN
                    state_d   = ST_WAIT2;
`else
                    short_d   = 1'b1;
                    state_d   = ST_IDLE;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (re) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if ((REPEAT_CNT != 0) && (cnt_q == REPEAT_LAST)) begin
                    rpt_d = 1'b1;
                    cnt_d = '0;
                end
            end

`ifdef KEY_DCLICK_EN
            ST_WAIT2: begin
                if (pe) begin
                    press_d  = 1'b1;
                    dclick_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_PRESS2;
                end else if (cnt_q == DCLICK_LAST) begin
                    short_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            // Second press of a double-click: untimed, only waits for release.
            ST_PRESS2: begin
                cnt_d = '0;
                if (re) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
`endif

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign short_o   = short_q;
    assign long_o    = long_q;
    assign repeat_o  = rpt_q;
    assign dclick_o  = dclick_q;
    assign pressed_o = pressed_q;

endmodule
